pc_redirect_ctrl: RTL

Program-counter owner and front-end redirect sequencer for the 5-stage core. Consumes the branch/jump decision (`PCNextSrc`) and target from EX, drives the instruction-memory request handshake, and generates IF/ID and ID/EX flush and stall controls. It also detects load-use hazards and counts taken redirects for performance monitoring.

---
 rtl/pc_redirect_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: PC owner, fetch handshake, redirect sequencing and load-use stall/flush control.
module pc_redirect_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_pc_next_src,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            stall_if,
  output logic            stall_id,
  output logic            target_misaligned,
  output logic [31:0]     redirect_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, redirect_q, redirect_d, aligned;
  logic [31:0] cnt_q, cnt_d;
  logic take, hazard;
  assign aligned = {ex_target[XLEN-1:2], 2'b00};
  assign take = state_q == RUN && ex_valid && ex_pc_next_src;
  assign hazard = state_q == RUN && ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                  (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign imem_req = state_q != BOOT;
  // PEND keeps presenting the old pc so the request stays stable until granted
  assign imem_addr = pc_q;
  assign flush_ifid = take || state_q == PEND;
  assign flush_idex = take || hazard || state_q == PEND;
  assign stall_if = hazard && !take;
  assign stall_id = hazard && !take;
  assign target_misaligned = take && |ex_target[1:0];
  assign redirect_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redirect_d = redirect_q;
    cnt_d = cnt_q;
    if (state_q == BOOT) state_d = RUN;
    else if (state_q == PEND) begin
      if (imem_gnt) begin
        pc_d = redirect_q;
        state_d = RUN;
      end
    end else if (take) begin
      cnt_d = cnt_q + 32'd1;
      if (imem_gnt) pc_d = aligned;
      else begin
        redirect_d = aligned;
        state_d = PEND;
      end
    end else if (!hazard && imem_gnt) pc_d = pc_q + XLEN'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      redirect_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      redirect_q <= redirect_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
